// File: rtl/dtw_band_shift_reg.sv
// Band-delay line between adjacent DTW cells: R+1 stages of cost words with
// per-stage valid bits, push/drain/clear control and a running fill count.
module dtw_band_shift_reg #(
    parameter int              WIDTH    = 8,
    parameter int              R        = 2,
    parameter logic [WIDTH-1:0] FILL_VAL = {WIDTH{1'b1}}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     drain,
    output logic [WIDTH-1:0]         last,
    output logic [WIDTH-1:0]         band,
    output logic [WIDTH-1:0]         out,
    output logic [(R+1)*WIDTH-1:0]   taps,
    output logic [R:0]               tap_valid,
    output logic                     out_valid,
    output logic [$clog2(R+2)-1:0]   fill_cnt,
    output logic                     primed
);

    localparam int CW = $clog2(R+2);

    logic [WIDTH-1:0] sreg_q [0:R];
    logic [WIDTH-1:0] sreg_d [0:R];
    logic             vld_q  [0:R];
    logic             vld_d  [0:R];
    logic [CW-1:0]    fill_cnt_q, fill_cnt_d;
    logic             primed_q, primed_d;

    logic             shift;
    logic [WIDTH-1:0] head_data;
    logic             head_vld;

    // A drain is just a push of a bubble; push wins when both are requested.
    always_comb begin
        shift     = in_valid | drain;
        head_data = in_valid ? in_data : FILL_VAL;
        head_vld  = in_valid;
    end

    for (genvar g = 0; g <= R; g++) begin : g_stage
        logic [WIDTH-1:0] src_data;
        logic             src_vld;
        logic [WIDTH-1:0] nxt_data;
        logic             nxt_vld;

        if (g == 0) begin : g_head
            assign src_data = head_data;
            assign src_vld  = head_vld;
        end else begin : g_tail
            assign src_data = sreg_q[g-1];
            assign src_vld  = vld_q[g-1];
        end

        always_comb begin
            nxt_data = sreg_q[g];
            nxt_vld  = vld_q[g];
            if (clr) begin
                nxt_data = FILL_VAL;
                nxt_vld  = 1'b0;
            end else if (shift) begin
                nxt_data = src_data;
                nxt_vld  = src_vld;
            end
        end

        assign sreg_d[g] = nxt_data;
        assign vld_d[g]  = nxt_vld;

        assign taps[g*WIDTH +: WIDTH] = sreg_q[g];
        assign tap_valid[g]           = vld_q[g];
    end

    // Count tracks popcount(vld): only the word entering and the word leaving
    // stage R can change it.
    always_comb begin
        fill_cnt_d = fill_cnt_q;
        if (clr) begin
            fill_cnt_d = '0;
        end else if (in_valid) begin
            if (!vld_q[R]) fill_cnt_d = fill_cnt_q + CW'(1);
        end else if (drain) begin
            if (vld_q[R]) fill_cnt_d = fill_cnt_q - CW'(1);
        end
        primed_d = (fill_cnt_d == CW'(R+1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= R; i++) begin
                sreg_q[i] <= FILL_VAL;
                vld_q[i]  <= 1'b0;
            end
            fill_cnt_q <= '0;
            primed_q   <= 1'b0;
        end else begin
            for (int i = 0; i <= R; i++) begin
                sreg_q[i] <= sreg_d[i];
                vld_q[i]  <= vld_d[i];
            end
            fill_cnt_q <= fill_cnt_d;
            primed_q   <= primed_d;
        end
    end

    assign last      = sreg_q[0];
    assign band      = sreg_q[R-1];
    assign out       = sreg_q[R];
    assign out_valid = vld_q[R];
    assign fill_cnt  = fill_cnt_q;
    assign primed    = primed_q;

endmodule

// File: tb/tb_dtw_band_shift_reg.sv
// Directed bench for dtw_band_shift_reg (WIDTH=8, R=2) with hand-computed expectations.
module tb_dtw_band_shift_reg;

    localparam int WIDTH = 8;
    localparam int R     = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   clr;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   drain;
    logic [WIDTH-1:0]       last, band, out;
    logic [(R+1)*WIDTH-1:0] taps;
    logic [R:0]             tap_valid;
    logic                   out_valid;
    logic [$clog2(R+2)-1:0] fill_cnt;
    logic                   primed;

    int n_checks = 0;
    int n_errors = 0;

    dtw_band_shift_reg #(.WIDTH(WIDTH), .R(R)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .in_data(in_data), .drain(drain), .last(last), .band(band),
        .out(out), .taps(taps), .tap_valid(tap_valid), .out_valid(out_valid),
        .fill_cnt(fill_cnt), .primed(primed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr = 1'b0; in_valid = 1'b0; drain = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
    endtask

    task automatic do_drain();
        drain = 1'b1;
        tick();
    endtask

    logic [1:0] exp_fill [4]  = '{2'd2, 2'd1, 2'd0, 2'd0};
    logic [7:0] exp_out  [4]  = '{8'h22, 8'h33, 8'hFF, 8'hFF};
    logic       exp_ov   [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; drain = 1'b0;
        #12;
        check("rst_last", last, 8'hFF);
        check("rst_band", band, 8'hFF);
        check("rst_out", out, 8'hFF);
        check("rst_taps", taps, 24'hFFFFFF);
        check("rst_tap_valid", tap_valid, 3'b000);
        check("rst_fill", fill_cnt, 0);
        check("rst_primed", primed, 0);
        check("rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        tick();

        // Push sequence
        push(8'h11);
        check("p1_last", last, 8'h11);
        check("p1_fill", fill_cnt, 1);
        check("p1_tv", tap_valid, 3'b001);
        check("p1_primed", primed, 0);
        push(8'h22);
        push(8'h33);
        check("p3_last", last, 8'h33);
        check("p3_band", band, 8'h22);
        check("p3_out", out, 8'h11);
        check("p3_primed", primed, 1);
        check("p3_fill", fill_cnt, 3);
        check("p3_taps", taps, 24'h112233);
        check("p3_ov", out_valid, 1);
        push(8'h44);
        check("p4_out", out, 8'h22);
        check("p4_last", last, 8'h44);
        check("p4_fill", fill_cnt, 3);
        check("p4_primed", primed, 1);

        // clr beats in_valid
        clr = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        tick();
        check("clr_taps", taps, 24'hFFFFFF);
        check("clr_tv", tap_valid, 3'b000);
        check("clr_fill", fill_cnt, 0);
        check("clr_primed", primed, 0);

        // Stall: idle cycles hold state
        push(8'h11);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_last", last, 8'h11);
            check("stall_fill", fill_cnt, 1);
        end
        push(8'h22);
        check("stall_band", band, 8'h11);
        check("stall_last2", last, 8'h22);
        check("stall_fill2", fill_cnt, 2);

        // Drain from full {33,22,11}
        push(8'h33);
        check("full_taps", taps, 24'h112233);
        for (int i = 0; i < 4; i++) begin
            do_drain();
            check("drn_fill", fill_cnt, exp_fill[i]);
            check("drn_out", out, exp_out[i]);
            check("drn_ov", out_valid, exp_ov[i]);
        end
        check("drn_taps", taps, 24'hFFFFFF);
        check("drn_tv", tap_valid, 3'b000);

        // push wins over drain
        drain = 1'b1; in_valid = 1'b1; in_data = 8'h66;
        tick();
        check("pri_last", last, 8'h66);
        check("pri_fill", fill_cnt, 1);
        check("pri_tv", tap_valid, 3'b001);

        // drain with invalid stage R keeps count
        do_drain();
        check("pd_fill", fill_cnt, 1);
        check("pd_tv", tap_valid, 3'b010);
        check("pd_last", last, 8'hFF);
        push(8'h77);
        check("pd_fill2", fill_cnt, 2);
        check("pd_tv2", tap_valid, 3'b101);
        push(8'h88);
        check("pd_fill3", fill_cnt, 2);
        check("pd_tv3", tap_valid, 3'b011);
        check("pd_out", out, 8'hFF);
        check("pd_ov", out_valid, 0);
        push(8'h99);
        check("pd_primed", primed, 1);
        check("pd_taps", taps, 24'h778899);
        push(8'hAA);
        check("ev_primed", primed, 1);
        check("ev_out", out, 8'h88);
        check("ev_fill", fill_cnt, 3);

        // Async reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("ar_last", last, 8'hFF);
        check("ar_out", out, 8'hFF);
        check("ar_taps", taps, 24'hFFFFFF);
        check("ar_tv", tap_valid, 3'b000);
        check("ar_fill", fill_cnt, 0);
        check("ar_primed", primed, 0);
        #2 rst_n = 1'b1;
        tick();
        push(8'h5A);
        check("post_last", last, 8'h5A);
        check("post_fill", fill_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
